// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with blanking dead time
// and frame-synchronous double-buffered value updates.
module display_scan_ctrl #(
  parameter int unsigned TICK_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  output logic [7:0]  z,
  output logic [3:0]  an,
  output logic        frame_done,
  output logic        pending
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [15:0] TICK_LAST  = 16'(TICK_DIV - 1);
  localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [1:0]  idx;
  logic [1:0]  idx_n;
  logic [15:0] cnt;
  logic [15:0] cnt_n;
  logic [15:0] shadow;
  logic [15:0] shadow_n;
  logic [15:0] pend_val;
  logic [15:0] pend_val_n;
  logic        pending_n;
  logic        boundary;
  logic        lit_n;
  logic [3:0]  nib_n;
  logic [7:0]  z_n;
  logic [3:0]  an_n;
  logic        fd_n;

  function automatic logic [7:0] encode(input logic [3:0] n);
    logic [7:0] s;
    s = 8'hFF;
    unique case (n)
      4'h0: s = 8'h03;
      4'h1: s = 8'h9F;
      4'h2: s = 8'h25;
      4'h3: s = 8'h0D;
      4'h4: s = 8'h99;
      4'h5: s = 8'h49;
      4'h6: s = 8'h41;
      4'h7: s = 8'h1F;
      4'h8: s = 8'h01;
      4'h9: s = 8'h09;
      4'hA: s = 8'h11;
      4'hB: s = 8'hC1;
      4'hC: s = 8'h63;
      4'hD: s = 8'h85;
      4'hE: s = 8'h61;
      4'hF: s = 8'h71;
    endcase
    return s;
  endfunction

  // Slot sequencing: BLANK then SHOW per digit, index advances after SHOW.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 16'd1;
    unique case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = 16'd0;
        end
      end
      SHOW: begin
        if (cnt == TICK_LAST) begin
          state_n = BLANK;
          idx_n   = idx + 2'd1;
          cnt_n   = 16'd0;
        end
      end
    endcase
  end

  assign boundary = (state == SHOW) &&
                    (idx == 2'd3) &&
                    (cnt == TICK_LAST);

  // Double buffer: the shadow only changes at the frame boundary,
  // so a single frame never mixes nibbles from two loads.
  always_comb begin
    shadow_n   = shadow;
    pend_val_n = pend_val;
    pending_n  = pending;
    if (boundary) begin
      pending_n = 1'b0;
      if (load) begin
        shadow_n   = value;
        pend_val_n = value;
      end else if (pending) begin
        shadow_n = pend_val;
      end
    end else if (load) begin
      pend_val_n = value;
      pending_n  = 1'b1;
    end
  end

  // Outputs are derived from next-state values and registered, so
  // they line up with the state they describe and have no input path.
  always_comb begin
    nib_n = shadow_n[{idx_n, 2'b00} +: 4];
    lit_n = (state_n == SHOW) && digit_en[idx_n];
    z_n   = lit_n ? encode(nib_n) : 8'hFF;
    an_n  = lit_n ? ~(4'b0001 << idx_n) : 4'hF;
    fd_n  = (state_n == SHOW) &&
            (idx_n == 2'd3) &&
            (cnt_n == TICK_LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= BLANK;
      idx        <= 2'd0;
      cnt        <= 16'd0;
      shadow     <= 16'h0000;
      pend_val   <= 16'h0000;
      pending    <= 1'b0;
      z          <= 8'hFF;
      an         <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      shadow     <= shadow_n;
      pend_val   <= pend_val_n;
      pending    <= pending_n;
      z          <= z_n;
      an         <= an_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random
// loads/enables/resets checked against a frame-position model.
module tb_display_scan_ctrl;

  localparam int TD = 4;
  localparam int BC = 2;
  localparam int SLOT = TD + BC;
  localparam int FP = 4 * SLOT;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  digit_en = 4'hF;
  logic [7:0]  z;
  logic [3:0]  an;
  logic        frame_done;
  logic        pending;

  int n_chk = 0;
  int n_fail = 0;

  int          t = 0;
  logic [15:0] m_sh = 16'h0;
  logic [15:0] m_pv = 16'h0;
  bit          m_pend = 1'b0;
  logic [3:0]  m_en = 4'hF;

  logic [7:0] seg_tab [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  display_scan_ctrl #(
    .TICK_DIV(TD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .load(load),
    .value(value),
    .digit_en(digit_en),
    .z(z),
    .an(an),
    .frame_done(frame_done),
    .pending(pending)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s t=%0d: observed %h expected %h",
             tag, t, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int pos, d, w;
    bit on;
    logic [3:0] ea;
    logic [7:0] ez;
    pos = t % FP;
    d = pos / SLOT;
    w = pos % SLOT;
    on = (w >= BC) && m_en[d];
    ea = on ? ~(4'b0001 << d) : 4'hF;
    ez = on ? seg_tab[4'(m_sh >> (4 * d))] : 8'hFF;
    chk("an", {12'h0, an}, {12'h0, ea});
    chk("z", {8'h0, z}, {8'h0, ez});
    chk("frame_done", {15'h0, frame_done}, {15'h0, (pos == FP - 1)});
    chk("pending", {15'h0, pending}, {15'h0, m_pend});
  endtask

  task automatic model_edge();
    if (reset) begin
      t = 0;
      m_sh = 16'h0;
      m_pv = 16'h0;
      m_pend = 1'b0;
    end else begin
      if (t % FP == FP - 1) begin
        if (load) m_sh = value;
        else if (m_pend) m_sh = m_pv;
        m_pend = 1'b0;
      end else if (load) begin
        m_pv = value;
        m_pend = 1'b1;
      end
      t++;
    end
    m_en = digit_en;
  endtask

  task automatic cyc();
    check_outputs();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic run_to(input int k);
    int guard;
    guard = 0;
    while (t % FP != k && guard < 2 * FP) begin
      cyc();
      guard++;
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    value = v;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clock);
    model_edge();
    #1;
    reset = 1'b0;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_z", {8'h0, z}, 16'h00FF);
    repeat (FP) cyc();

    run_to(3);
    do_load(16'h1A2F);
    chk("pend_set", {15'h0, pending}, 16'h1);
    run_to(0);
    run_to(2);
    chk("ld_d0", {8'h0, z}, 16'h0071);
    run_to(8);
    chk("ld_d1", {8'h0, z}, 16'h0025);
    run_to(14);
    chk("ld_d2", {8'h0, z}, 16'h0011);
    run_to(20);
    chk("ld_d3", {8'h0, z}, 16'h009F);

    run_to(5);
    do_load(16'h1111);
    run_to(10);
    do_load(16'h8888);
    run_to(0);
    run_to(2);
    chk("latest_d0", {8'h0, z}, 16'h0001);
    run_to(8);
    chk("latest_d1", {8'h0, z}, 16'h0001);
    run_to(14);
    chk("latest_d2", {8'h0, z}, 16'h0001);
    run_to(20);
    chk("latest_d3", {8'h0, z}, 16'h0001);

    run_to(23);
    chk("fd_pulse", {15'h0, frame_done}, 16'h1);
    do_load(16'h0007);
    chk("bnd_pend", {15'h0, pending}, 16'h0);
    run_to(2);
    chk("bnd_d0", {8'h0, z}, 16'h001F);

    digit_en = 4'b0101;
    cyc();
    run_to(0);
    run_to(2);
    chk("en_d0", {12'h0, an}, 16'h000E);
    run_to(8);
    chk("en_d1_an", {12'h0, an}, 16'h000F);
    chk("en_d1_z", {8'h0, z}, 16'h00FF);
    run_to(14);
    chk("en_d2", {12'h0, an}, 16'h000B);
    run_to(20);
    chk("en_d3", {12'h0, an}, 16'h000F);
    run_to(23);
    chk("en_fd", {15'h0, frame_done}, 16'h1);

    digit_en = 4'hF;
    run_to(10);
    do_load(16'h1234);
    run_to(15);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_an", {12'h0, an}, 16'h000F);
    chk("mid_z", {8'h0, z}, 16'h00FF);
    chk("mid_pend", {15'h0, pending}, 16'h0);
    run_to(2);
    chk("mid_d0", {8'h0, z}, 16'h0003);
    run_to(23);
    chk("mid_fd", {15'h0, frame_done}, 16'h1);

    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
      reset = ($urandom_range(0, 149) == 0);
      cyc();
      load = 1'b0;
      reset = 1'b0;
    end
    run_to(0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 50000, clocks each digit is shown per scan slot; legal range 1..65535.
REQ-002 Parameter BLANK_CYCLES, default 500, clocks of all-off dead time before each digit; legal range 1..65535.
REQ-003 clock  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 load  in  1  one-clock strobe; captures value.
REQ-006 value  in  16  four hex nibbles; digit k = value[4k+3:4k].
REQ-007 digit_en  in  4  per-digit enable; bit k low blanks digit k (sampled live).
REQ-008 z  out  8  segments, active-low {a,b,c,d,e,f,g,dp}; dp always 1.
REQ-009 an  out  4  anode select, active-low one-hot; bit k drives digit k.
REQ-010 frame_done  out  1  one-clock pulse at the end of each full 4-digit scan.
REQ-011 pending  out  1  high while a captured value awaits the frame boundary.

Function
REQ-012 The block SHALL time-share one 7-segment bus across four digits via a 2-state FSM, BLANK and SHOW, plus a 2-bit digit index and a 16-bit slot counter.
REQ-013 BLANK SHALL last exactly BLANK_CYCLES clocks with an=1111 and z=0xFF, then go to SHOW with the same index.
REQ-014 SHOW SHALL last exactly TICK_DIV clocks with an[idx]=0 (others 1) and z=encode(shadow nibble idx); if digit_en[idx]=0, an=1111 and z=0xFF, but timing is unchanged.
REQ-015 At the end of SHOW the index SHALL increment modulo 4 (3 wraps to 0) and the FSM SHALL enter BLANK.
REQ-016 The frame period SHALL be exactly 4*(BLANK_CYCLES+TICK_DIV) clocks.
REQ-017 encode SHALL map 0..F to 03,9F,25,0D,99,49,41,1F,01,09,11,C1,63,85,61,71 (hex).
REQ-018 z, an and frame_done SHALL be registered outputs with no combinational path from inputs.
REQ-019 load=1 SHALL copy value into a pending register and set pending=1 on the next edge; a second load before the boundary overwrites it (latest wins).
REQ-020 The frame boundary is the last SHOW clock of digit 3; in that clock frame_done=1, and at its closing edge shadow<=pending register if pending=1, and pending<=0.
REQ-021 If load coincides with the boundary clock, shadow SHALL take the incoming value directly and pending SHALL end 0.
REQ-022 A displayed value SHALL never mix nibbles from two loads within one frame.
REQ-023 Worst-case load-to-display latency SHALL be one frame plus BLANK_CYCLES clocks.
REQ-024 frame_done SHALL be high for exactly one clock per frame and never in BLANK.

Reset
REQ-025 reset=1 at an edge SHALL set: state=BLANK, index=0, slot counter=0, shadow=0x0000, pending register=0, pending=0, an=1111, z=0xFF, frame_done=0.
REQ-026 reset SHALL override load and all FSM activity in the same edge, including mid-SHOW and at the boundary clock.
REQ-027 After reset is released, the first BLANK SHALL start fresh and last the full BLANK_CYCLES.

Verification (TICK_DIV=4, BLANK_CYCLES=2)
REQ-028 Reset then idle, digit_en=1111 -> cycles 0-1 an=1111; cycles 2-5 an=1110, z=0x03; digit 3 shows in cycles 20-23; frame_done=1 only at cycle 23; pattern repeats every 24 clocks.
REQ-029 load with value=0x1A2F in cycle 3 -> pending=1 from cycle 4 through 23; next frame shows digit0 z=0x71, digit1 z=0x25, digit2 z=0x11, digit3 z=0x9F.
REQ-030 load 0x1111 in cycle 5, then load 0x8888 in cycle 10 -> next frame shows z=0x01 on all digits; 0x9F never appears.
REQ-031 load 0x0007 exactly at a frame_done clock -> pending stays 0; digit0 shows z=0x1F in the very next SHOW.
REQ-032 digit_en=0101 -> an is 1110 and 1011 in the SHOW slots for digits 0 and 2; an=1111, z=0xFF in the slots for digits 1 and 3; frame period is still 24.
REQ-033 reset asserted mid-SHOW of digit 2 with pending=1 -> the next cycle has an=1111, z=0xFF, pending=0 and shadow 0; the scan restarts with the REQ-028 timing.
